// File: rtl/sha256_pkg.sv
// sha256_pkg: constants, types and round functions shared by the
// iterative SHA-256 controller (sha256_seq) and its round datapath.
package sha256_pkg;

  typedef logic [0:7][31:0]  hash_t;
  typedef logic [0:15][31:0] sched_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam hash_t H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(
    input logic [31:0] e,
    input logic [31:0] f,
    input logic [31:0] g
  );
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c
  );
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round,
// mapping working variables a..h (words 0..7) to their next values.
module sha256_round
  import sha256_pkg::*;
(
  input  hash_t       cur,
  input  logic [31:0] kt,
  input  logic [31:0] wt,
  output hash_t       nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = cur[7] + bsig1(cur[4])
       + ch(cur[4], cur[5], cur[6]) + kt + wt;
    t2 = bsig0(cur[0]) + maj(cur[0], cur[1], cur[2]);
    nxt = {t1 + t2, cur[0], cur[1], cur[2],
           cur[3] + t1, cur[4], cur[5], cur[6]};
  end

endmodule

// File: rtl/sha256_seq.sv
// sha256_seq: iterative SHA-256 controller, one round per clock.
// Optional SHA256_SEQ_PAD_EN pads a MSG_SIZE-bit message internally.
module sha256_seq
  import sha256_pkg::*;
#(
  parameter int ROUNDS   = 64,
  parameter int BLOCK_W  = 512,
  parameter int MSG_SIZE = 96
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic               in_first,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [255:0]       digest,
  output logic               busy
);

  if (BLOCK_W != 512 || MSG_SIZE > 447) begin : g_bad_cfg
    $error("sha256_seq: unsupported BLOCK_W/MSG_SIZE");
  end

  state_t       state;
  state_t       state_n;
  logic [6:0]   t;
  hash_t        h_q;
  hash_t        v_q;
  hash_t        v_nxt;
  hash_t        h_sum;
  sched_t       w_q;
  logic [31:0]  w_new;
  logic         last_q;
  logic         last_rnd;
  logic [511:0] blk;
  logic         first;
  logic         last;

`ifdef SHA256_SEQ_PAD_EN
  always_comb begin
    blk                     = '0;
    blk[511 -: MSG_SIZE]    = in_block[MSG_SIZE-1:0];
    blk[511 - MSG_SIZE]     = 1'b1;
    blk[63:0]               = 64'(MSG_SIZE);
    first                   = 1'b1;
    last                    = 1'b1;
  end
`else
  always_comb begin
    blk   = in_block;
    first = in_first;
    last  = in_last;
  end
`endif

  sha256_round u_round (
    .cur (v_q),
    .kt  (K[t[5:0]]),
    .wt  (w_q[0]),
    .nxt (v_nxt)
  );

  // Next schedule word enters at the tail as the head is consumed
  assign w_new = ssig1(w_q[14]) + w_q[9]
               + ssig0(w_q[1]) + w_q[0];

  assign last_rnd = (t == 7'(ROUNDS - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = h_q[i] + v_q[i];
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = ROUND;
      end
      ROUND: begin
        if (last_rnd) state_n = FINAL;
      end
      FINAL: begin
        state_n = last_q ? DONE : IDLE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      t      <= '0;
      h_q    <= H0;
      v_q    <= '0;
      w_q    <= '0;
      last_q <= 1'b0;
      digest <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            w_q    <= blk;
            v_q    <= first ? H0 : h_q;
            last_q <= last;
            t      <= '0;
            if (first) h_q <= H0;
          end
        end
        ROUND: begin
          v_q <= v_nxt;
          w_q <= {w_q[1:15], w_new};
          t   <= t + 7'd1;
        end
        FINAL: begin
          h_q <= h_sum;
          if (last_q) digest <= h_sum;
        end
        default: ;
      endcase
    end
  end

endmodule
